// File: rtl/dag_circ_addr_gen.sv
// DAG: I/M/L/B register file with pre/post-modify addressing and
// single-correction circular-buffer wrap, routed to the DM or PM address bus.
module dag_circ_addr_gen #(
  parameter int DW   = 16,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ps_dg_en,
  input  logic          ps_dg_dgsclt,
  input  logic          ps_dg_mdfy,
  input  logic [2:0]    ps_dg_iadd,
  input  logic [2:0]    ps_dg_madd,
  input  logic          ps_dg_wrt_en,
  input  logic [4:0]    ps_dg_wrt_add,
  input  logic [4:0]    ps_dg_rd_add,
  input  logic [DW-1:0] bc_dg_dt,
  output logic [DW-1:0] dg_bc_dt,
  output logic [DW-1:0] dg_dm_add,
  output logic [DW-1:0] dg_ps_add,
  output logic          dg_cbuf_wrap
);

  logic [DW-1:0] i_q [NREG];
  logic [DW-1:0] m_q [NREG];
  logic [DW-1:0] l_q [NREG];
  logic [DW-1:0] b_q [NREG];
  logic          wrap_q;
  logic          wrap_d;

  logic [DW-1:0]        iv, mv, lv, bv;
  logic signed [DW+1:0] sum, lim, base;
  logic [DW-1:0]        nxt;
  logic [DW-1:0]        addr;
  logic                 wrap;
  logic                 post;

  assign iv   = i_q[ps_dg_iadd];
  assign mv   = m_q[ps_dg_madd];
  assign lv   = l_q[ps_dg_iadd];
  assign bv   = b_q[ps_dg_iadd];
  assign post = ps_dg_en && !ps_dg_mdfy;

  // I is an unsigned address, M a signed step; two guard bits avoid overflow
  assign sum  = $signed({2'b00, iv}) + $signed({{2{mv[DW-1]}}, mv});
  assign base = $signed({2'b00, bv});
  assign lim  = $signed({2'b00, bv}) + $signed({2'b00, lv});

  always_comb begin
    nxt  = sum[DW-1:0];
    wrap = 1'b0;
    if (lv != '0) begin
      if (!mv[DW-1] && (sum >= lim)) begin
        nxt  = sum[DW-1:0] - lv;
        wrap = 1'b1;
      end else if (mv[DW-1] && (sum < base)) begin
        nxt  = sum[DW-1:0] + lv;
        wrap = 1'b1;
      end
    end
  end

  assign addr      = ps_dg_mdfy ? sum[DW-1:0] : iv;
  assign dg_dm_add = (ps_dg_en && !ps_dg_dgsclt) ? addr : '0;
  assign dg_ps_add = (ps_dg_en &&  ps_dg_dgsclt) ? addr : '0;
  assign wrap_d    = post && wrap;

  always_comb begin
    dg_bc_dt = '0;
    if (ps_dg_wrt_en && (ps_dg_wrt_add == ps_dg_rd_add)) begin
      dg_bc_dt = bc_dg_dt;
    end else begin
      unique case (ps_dg_rd_add[4:3])
        2'b00: dg_bc_dt = i_q[ps_dg_rd_add[2:0]];
        2'b01: dg_bc_dt = m_q[ps_dg_rd_add[2:0]];
        2'b10: dg_bc_dt = l_q[ps_dg_rd_add[2:0]];
        2'b11: dg_bc_dt = b_q[ps_dg_rd_add[2:0]];
        default: dg_bc_dt = '0;
      endcase
    end
  end

  // ureg write is applied after the post-modify update so it wins a collision
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NREG; k++) begin
        i_q[k] <= '0;
        m_q[k] <= '0;
        l_q[k] <= '0;
        b_q[k] <= '0;
      end
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      if (post) i_q[ps_dg_iadd] <= nxt;
      if (ps_dg_wrt_en) begin
        unique case (ps_dg_wrt_add[4:3])
          2'b00: i_q[ps_dg_wrt_add[2:0]] <= bc_dg_dt;
          2'b01: m_q[ps_dg_wrt_add[2:0]] <= bc_dg_dt;
          2'b10: l_q[ps_dg_wrt_add[2:0]] <= bc_dg_dt;
          2'b11: b_q[ps_dg_wrt_add[2:0]] <= bc_dg_dt;
          default: ;
        endcase
      end
    end
  end

  assign dg_cbuf_wrap = wrap_q;

endmodule

// File: tb/tb_dag_circ_addr_gen.sv
// Bench for dag_circ_addr_gen: cycle-by-cycle behavioural model compare
// plus literal checks pinning the directed address sequences.
module tb_dag_circ_addr_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, sclt = 1'b0, mdfy = 1'b0;
  logic [2:0]  iadd = '0, madd = '0;
  logic        wen = 1'b0;
  logic [4:0]  wadd = '0, radd = '0;
  logic [15:0] wdat = '0;
  logic [15:0] bc, dm, ps;
  logic        wrp;

  int n_cmp = 0;
  int n_bad = 0;

  int mI[8], mM[8], mL[8], mB[8];
  bit mwrap;

  always #5 clk = ~clk;

  dag_circ_addr_gen #(.DW(16), .NREG(8)) dut (
    .clk(clk), .rst(rst),
    .ps_dg_en(en), .ps_dg_dgsclt(sclt), .ps_dg_mdfy(mdfy),
    .ps_dg_iadd(iadd), .ps_dg_madd(madd),
    .ps_dg_wrt_en(wen), .ps_dg_wrt_add(wadd), .ps_dg_rd_add(radd),
    .bc_dg_dt(wdat), .dg_bc_dt(bc),
    .dg_dm_add(dm), .dg_ps_add(ps), .dg_cbuf_wrap(wrp)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_eval(output int addr, output int nxt, output bit w);
    int i, m, s;
    i = mI[iadd];
    m = mM[madd];
    if (m >= 32768) m = m - 65536;
    s = i + m;
    addr = mdfy ? (s & 65535) : i;
    nxt = s;
    w = 1'b0;
    if (mL[iadd] != 0) begin
      if (m >= 0 && s >= mB[iadd] + mL[iadd]) begin
        nxt = s - mL[iadd];
        w = 1'b1;
      end else if (m < 0 && s < mB[iadd]) begin
        nxt = s + mL[iadd];
        w = 1'b1;
      end
    end
    nxt = nxt & 65535;
  endtask

  function automatic int model_rd();
    int k;
    k = int'(radd[2:0]);
    if (wen && wadd == radd) return int'(wdat);
    case (radd[4:3])
      2'b00: return mI[k];
      2'b01: return mM[k];
      2'b10: return mL[k];
      default: return mB[k];
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    int a, nx, k;
    bit w;
    if (!rst) begin
      for (int j = 0; j < 8; j++) begin
        mI[j] = 0; mM[j] = 0; mL[j] = 0; mB[j] = 0;
      end
      mwrap = 1'b0;
    end else begin
      model_eval(a, nx, w);
      mwrap = en && !mdfy && w;
      if (en && !mdfy) mI[iadd] = nx;
      if (wen) begin
        k = int'(wadd[2:0]);
        case (wadd[4:3])
          2'b00: mI[k] = int'(wdat);
          2'b01: mM[k] = int'(wdat);
          2'b10: mL[k] = int'(wdat);
          default: mB[k] = int'(wdat);
        endcase
      end
    end
  end

  always @(negedge clk) begin
    int a, nx;
    bit w;
    if (rst) begin
      model_eval(a, nx, w);
      chk("model_dm", int'(dm), (en && !sclt) ? a : 0);
      chk("model_ps", int'(ps), (en && sclt) ? a : 0);
      chk("model_rd", int'(bc), model_rd());
      chk("model_wrap", int'(wrp), int'(mwrap));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; wen = 1'b0; mdfy = 1'b0; sclt = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    idle();
    wen = 1'b1; wadd = a; wdat = d;
    step();
    wen = 1'b0;
  endtask

  task automatic acc(input logic [2:0] i, input logic [2:0] m,
                     input logic pre, input logic pm);
    wen = 1'b0; en = 1'b1; iadd = i; madd = m; mdfy = pre; sclt = pm;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_dm", int'(dm), 0);
    chk("rst_ps", int'(ps), 0);
    chk("rst_wrap", int'(wrp), 0);
    #5 rst = 1'b1;
    step();

    wr(5'd0, 16'h0010);
    wr(5'd8, 16'h0004);
    wr(5'd16, 16'h0000);
    acc(3'd0, 3'd0, 1'b0, 1'b0);
    at_neg(); chk("lin_a0", int'(dm), 'h10); step();
    at_neg(); chk("lin_a1", int'(dm), 'h14); step();
    at_neg(); chk("lin_a2", int'(dm), 'h18); step();
    idle(); radd = 5'd0;
    at_neg(); chk("lin_i0", int'(bc), 'h1C); chk("lin_wrap", int'(wrp), 0);
    step();

    wr(5'd25, 16'h0100);
    wr(5'd17, 16'h0008);
    wr(5'd1, 16'h0106);
    wr(5'd9, 16'h0003);
    acc(3'd1, 3'd1, 1'b0, 1'b0);
    at_neg(); chk("pos_addr", int'(dm), 'h106); step();
    idle(); radd = 5'd1;
    at_neg(); chk("pos_i1", int'(bc), 'h101); chk("pos_wrap", int'(wrp), 1);
    step();
    at_neg(); chk("pos_wrap_end", int'(wrp), 0);

    wr(5'd10, 16'hFFFD);
    acc(3'd1, 3'd2, 1'b0, 1'b0);
    at_neg(); chk("neg_addr", int'(dm), 'h101); step();
    idle(); radd = 5'd1;
    at_neg(); chk("neg_i1", int'(bc), 'h106); chk("neg_wrap", int'(wrp), 1);
    step();

    wr(5'd1, 16'h0105);
    acc(3'd1, 3'd1, 1'b0, 1'b0);
    step();
    idle(); radd = 5'd1;
    at_neg(); chk("edge_hi_i1", int'(bc), 'h100); chk("edge_hi_wrap", int'(wrp), 1);
    step();
    wr(5'd1, 16'h0103);
    acc(3'd1, 3'd2, 1'b0, 1'b0);
    step();
    idle(); radd = 5'd1;
    at_neg(); chk("edge_lo_i1", int'(bc), 'h100); chk("edge_lo_wrap", int'(wrp), 0);
    step();

    wr(5'd3, 16'h0200);
    wr(5'd11, 16'h0010);
    acc(3'd3, 3'd3, 1'b1, 1'b1);
    at_neg(); chk("pre_ps", int'(ps), 'h210); chk("pre_dm", int'(dm), 0);
    step();
    idle(); radd = 5'd3;
    at_neg(); chk("pre_i3", int'(bc), 'h200); chk("pre_wrap", int'(wrp), 0);
    step();

    acc(3'd4, 3'd0, 1'b0, 1'b0);
    wen = 1'b1; wadd = 5'd4; wdat = 16'h1234; radd = 5'd4;
    at_neg(); chk("byp_rd", int'(bc), 'h1234); chk("col_addr", int'(dm), 0);
    step();
    idle(); radd = 5'd4;
    at_neg(); chk("col_i4", int'(bc), 'h1234);
    step();

    wr(5'd1, 16'h0106);
    acc(3'd1, 3'd1, 1'b0, 1'b0);
    radd = 5'd1;
    at_neg(); chk("prerst_addr", int'(dm), 'h106);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_dm", int'(dm), 0);
    chk("mid_rst_rd", int'(bc), 0);
    chk("mid_rst_wrap", int'(wrp), 0);
    step();
    idle();
    rst = 1'b1;
    radd = 5'd9;
    at_neg(); chk("post_rst_m1", int'(bc), 0); chk("post_rst_wrap", int'(wrp), 0);
    radd = 5'd25;
    #1 chk("post_rst_b1", int'(bc), 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
